mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit. It sits beside alu on the same operand bus.
//  Decode presents src_A/src_B and start; the HI/LO result feeds the writeback mux
//  (MFHI/MFLO). Multi-cycle: the controller stalls the PC while busy is high.
// PARAMETERS
//  WIDTH   32   operand/result width; only 32 is supported
// PORTS
//  clk          in   1    rising-edge clock
//  rst_n        in   1    async active-low reset
//  start        in   1    request operation; accepted only when busy==0
//  op           in   2    00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//  src_A        in   32   multiplicand / dividend; sampled on accept
//  src_B        in   32   multiplier / divisor; sampled on accept
//  hi_we        in   1    MTHI: hi <= wdata; honoured only if idle and no start
//  lo_we        in   1    MTLO: lo <= wdata; same rules as hi_we
//  wdata        in   32   MTHI/MTLO data
//  busy         out  1    operation in flight
//  done         out  1    one-cycle pulse; hi/lo valid in this cycle
//  div_by_zero  out  1    pulses with done when a divide had src_B==0
//  hi           out  32   HI register (mult upper / div remainder)
//  lo           out  32   LO register (mult lower / div quotient)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0; done=0; div_by_zero=0; hi=lo=0; counter=0.
//  FSM: IDLE -> RUN on accept; RUN -> FIN after 32nd iteration; FIN -> IDLE (or RUN if start).
//  Accept = start & (state!=RUN). Operands and op are latched on the accepting edge (E0).
//  RUN: one bit per edge, E1..E32, with a 6-bit counter. busy=1 from after E0 through E32.
//  Multiply: shift-add into a 64-bit accumulator. Divide: restoring, 33-bit partial remainder.
//  On E32: hi/lo loaded; state=FIN. In FIN: busy=0, done=1 for exactly one cycle.
//  A start in the FIN cycle is accepted (back-to-back); done still pulses once.
//  Divide by zero: RUN is skipped. The accept edge goes straight to FIN.
//   Result: lo=32'hFFFF_FFFF, hi=src_A (raw), div_by_zero=1 with done.
//  start while busy: ignored, with no effect on the operation in flight.
//  hi_we/lo_we while busy or in the same cycle as an accepted start: dropped.
//  hi_we and lo_we together while idle: both written.
//  hi/lo hold their value until the next done or MTHI/MTLO; they are never cleared by start.
//  Signed ops (op[1]=1): operands are converted to magnitude on accept and the result negated at E32.
//   Product sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31].
//   0x8000_0000 / -1: lo=0x8000_0000, hi=0 (no trap).
//  rst_n asserted mid-operation: the operation is aborted, all state is reset, and no done.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: MULT/DIV are signed as above. The sign and negate logic is present.
//  MULDIV_SIGNED_EN undefined: op[1] is ignored; all ops are unsigned (MULT==MULTU, DIV==DIVU).
//   Timing, handshake and divide-by-zero behaviour are unchanged.
// TESTING
//  MULTU 7*6 at E0 -> busy 32 cycles; done in cycle 33; hi=0, lo=42.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIVU 100/7 -> lo=14, hi=2; div_by_zero=0.
//  DIV -7/2 (MULDIV_SIGNED_EN) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   Without the macro: lo=0x7FFFFFFC, hi=1.
//  DIVU 5/0 -> done the cycle after accept; lo=0xFFFFFFFF, hi=5, div_by_zero=1.
//  Second start at cycle 10 -> ignored. rst_n=0 at cycle 20 -> busy=0, hi=lo=0, no done.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit producing HI/LO (MULTU, DIVU, MULT, DIV).
// Latency: 32 iterations after the accept edge; done pulses in the following cycle (divide by zero: the cycle after accept).
// Backpressure: start is ignored while busy; MTHI/MTLO writes are dropped while busy or when a start is accepted.
// Ports: clk, rst_n (async active-low), start/op/src_A/src_B request, hi_we/lo_we/wdata direct writes,
//        busy/done/div_by_zero status, hi/lo result registers.
// Optional feature: define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise op[1] is ignored.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q;
    logic             div_q;        // latched op[0]: 1 = divide
    logic             neg_lo_q;     // negate product / quotient at the end
    logic             neg_hi_q;     // negate remainder (product uses neg_lo_q for both halves)
    logic             dbz_q;
    logic [WIDTH-1:0] opnd_q;       // multiplicand (mult) or divisor (div), magnitude
    logic [WIDTH-1:0] acc_hi_q;     // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;     // multiplier being consumed / dividend becoming quotient
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept, signed_op, is_div, dbz_now, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept  = start && (state_q != RUN);
    assign is_div  = op[0];
    assign dbz_now = is_div && (src_B == '0);

`ifdef MULDIV_SIGNED_EN
    assign signed_op = op[1];
`else
    assign signed_op = 1'b0;
    logic unused_op1;
    assign unused_op1 = op[1];
`endif

    assign a_neg = signed_op & src_A[WIDTH-1];
    assign b_neg = signed_op & src_B[WIDTH-1];
    assign a_mag = a_neg ? (~src_A + 1'b1) : src_A;
    assign b_mag = b_neg ? (~src_B + 1'b1) : src_B;

    // One iteration of the datapath, shared between mult and div.
    logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] acc_hi_d, acc_lo_d, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, opnd_q};
        rem_sub  = rem_sh - {1'b0, opnd_q};
        acc_hi_d = '0;
        acc_lo_d = '0;
        res_hi   = '0;
        res_lo   = '0;
        prod     = '0;
        if (div_q) begin
            // Remainder is always below the divisor, so it fits in WIDTH bits.
            acc_hi_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
            res_lo   = neg_lo_q ? (~acc_lo_d + 1'b1) : acc_lo_d;
            res_hi   = neg_hi_q ? (~acc_hi_d + 1'b1) : acc_hi_d;
        end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            prod     = {acc_hi_d, acc_lo_d};
            if (neg_lo_q) prod = ~prod + 1'b1;
            res_hi   = prod[2*WIDTH-1:WIDTH];
            res_lo   = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = (cnt_q == 6'd31) ? FIN : RUN;
            default: begin
                if (accept) state_d = dbz_now ? FIN : RUN;
                else        state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == FIN);
    assign div_by_zero = done & dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q    <= '0;
                div_q    <= is_div;
                dbz_q    <= dbz_now;
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= is_div ? a_neg : (a_neg ^ b_neg);
                acc_hi_q <= '0;
                acc_lo_q <= is_div ? a_mag : b_mag;
                opnd_q   <= is_div ? b_mag : a_mag;
                if (dbz_now) begin
                    hi_q <= src_A;
                    lo_q <= '1;
                end
            end else if (state_q == RUN) begin
                cnt_q    <= cnt_q + 6'd1;
                acc_hi_q <= acc_hi_d;
                acc_lo_q <= acc_lo_d;
                if (cnt_q == 6'd31) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

endmodule
